alarm_controller: RTL and testbench



---
 rtl/alarm_controller.sv | 179 +++++++++++++++++
 tb/tb_alarm_controller.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_controller.sv
`default_nettype none
// ============================================================================
//  Module   : alarm_controller (with package alarm_controller_pkg)
//  Purpose  : Top-level keypad-alarm state machine. Arms from a push button,
//             counts down an entry delay after a sensor trip, then sounds the
//             siren for a fixed time before re-arming automatically. A
//             correct passcode disarms from SET or TRIGGER.
//  Ports    : clk              - system clock
//             rst              - synchronous active-high reset
//             btn1             - arm button, active-low, debounced
//             sensor           - door/motion sensor, asynchronous, active-high
//             passcode_correct - passcode checker holds a correct entry
//             system_state     - current FSM state (fsm_state_t)
//             timer            - entry-delay seconds remaining
//             siren            - high in STATE_ALARM
//             armed            - high in any state except STATE_IDLE
//  Revision : 1.0 - initial release
// ============================================================================

package alarm_controller_pkg;
  typedef enum logic [1:0] {
    STATE_IDLE    = 2'd0,
    STATE_SET     = 2'd1,
    STATE_TRIGGER = 2'd2,
    STATE_ALARM   = 2'd3
  } fsm_state_t;
endpackage

module alarm_controller
  import alarm_controller_pkg::*;
#(
  parameter int CLK_HZ        = 50_000_000,
  parameter int ENTRY_DELAY_S = 15,
  parameter int ALARM_S       = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn1,
  input  logic               sensor,
  input  logic               passcode_correct,
  output fsm_state_t         system_state,
  output logic signed [31:0] timer,
  output logic               siren,
  output logic               armed
);

  localparam int                   c_pre_w   = $clog2(CLK_HZ);
  localparam logic [c_pre_w-1:0]   c_pre_max = c_pre_w'(CLK_HZ - 1);
  localparam logic signed [31:0]   c_entry   = 32'(ENTRY_DELAY_S);
  localparam logic [31:0]          c_alarm   = 32'(ALARM_S);

  // Input conditioning
  logic r_arm_prev;
  logic r_arm_pulse;
  logic r_sync1;
  logic r_sensor_s;

  // State and counters
  fsm_state_t         r_state;
  fsm_state_t         w_state_nxt;
  logic signed [31:0] r_timer;
  logic signed [31:0] w_timer_nxt;
  logic [31:0]        r_alarm_cnt;
  logic [31:0]        w_alarm_nxt;
  logic [c_pre_w-1:0] r_pre;
  logic               w_tick;

  // Button is active-low: invert, then fire a single pulse on the press edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_arm_prev  <= 1'b0;
      r_arm_pulse <= 1'b0;
    end else begin
      r_arm_prev  <= ~btn1;
      r_arm_pulse <= ~btn1 & ~r_arm_prev;
    end
  end

  // Two-flop synchroniser for the asynchronous sensor.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_sensor_s <= 1'b0;
    end else begin
      r_sync1    <= sensor;
      r_sensor_s <= r_sync1;
    end
  end

  assign w_tick = (r_pre == c_pre_max);

  // One-second prescaler. Cleared on every state change so that each
  // countdown starts from a full second; idle in the unarmed/waiting states.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre <= '0;
    end else if ((w_state_nxt != r_state) || (r_state == STATE_IDLE) ||
                 (r_state == STATE_SET)) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_alarm_nxt = r_alarm_cnt;
    case (r_state)
      STATE_IDLE: begin
        // passcode_correct deliberately ignored: the checker holds it one
        // cycle past disarm and that must not be treated as anything here.
        w_timer_nxt = c_entry;
        if (r_arm_pulse) begin
          w_state_nxt = STATE_SET;
        end
      end
      STATE_SET: begin
        w_timer_nxt = c_entry;
        if (passcode_correct) begin
          w_state_nxt = STATE_IDLE;
        end else if (r_sensor_s) begin
          w_state_nxt = STATE_TRIGGER;
        end
      end
      STATE_TRIGGER: begin
        // Disarm wins over the final tick.
        if (passcode_correct) begin
          w_state_nxt = STATE_IDLE;
          w_timer_nxt = c_entry;
        end else if (w_tick) begin
          if (r_timer <= 32'sd1) begin
            w_state_nxt = STATE_ALARM;
            w_timer_nxt = '0;
            w_alarm_nxt = c_alarm;
          end else begin
            w_timer_nxt = r_timer - 32'sd1;
          end
        end
      end
      STATE_ALARM: begin
        w_timer_nxt = '0;
        if (w_tick) begin
          if (r_alarm_cnt <= 32'd1) begin
            w_state_nxt = STATE_SET;
            w_timer_nxt = c_entry;
          end else begin
            w_alarm_nxt = r_alarm_cnt - 32'd1;
          end
        end
      end
      default: begin
        w_state_nxt = STATE_IDLE;
        w_timer_nxt = c_entry;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= STATE_IDLE;
      r_timer     <= c_entry;
      r_alarm_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_alarm_cnt <= w_alarm_nxt;
    end
  end

  assign system_state = r_state;
  assign timer        = r_timer;
  assign siren        = (r_state == STATE_ALARM);
  assign armed        = (r_state != STATE_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alarm_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alarm_controller
//  Purpose  : Scoreboard bench for alarm_controller with CLK_HZ=4,
//             ENTRY_DELAY_S=3, ALARM_S=2. Stimulus pushes the expected
//             outputs for a cycle; a negedge monitor pops and compares.
//  Revision : 1.1 - added reset-state, watchdog and completion checks
// ============================================================================
module tb_alarm_controller;
    import alarm_controller_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               btn1;
    logic               sensor;
    logic               passcode_correct;
    fsm_state_t         system_state;
    logic signed [31:0] timer;
    logic               siren;
    logic               armed;

    alarm_controller #(
        .CLK_HZ       (4),
        .ENTRY_DELAY_S(3),
        .ALARM_S      (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .btn1            (btn1),
        .sensor          (sensor),
        .passcode_correct(passcode_correct),
        .system_state    (system_state),
        .timer           (timer),
        .siren           (siren),
        .armed           (armed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] st;
        int         tm;
        logic       sr;
        logic       ar;
        string      name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic r_done = 1'b0;

    // Monitor: outputs are sampled on the falling edge, half a cycle away from
    // the active edge; every expectation queued for this cycle is consumed.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (system_state !== e.st || timer !== e.tm || siren !== e.sr ||
                armed !== e.ar) begin
                errors++;
                $display("FAIL %s: got state=%0d timer=%0d siren=%0b armed=%0b, want state=%0d timer=%0d siren=%0b armed=%0b",
                         e.name, system_state, timer, siren, armed, e.st, e.tm, e.sr, e.ar);
            end
        end
    end

    // Watchdog: the stimulus sequence must complete within a bounded time.
    initial begin
        repeat (2000) @(posedge clk);
        if (!r_done) begin
            errors++;
            $display("FAIL timeout: stimulus did not complete within 2000 cycles");
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    // Advance one active edge, then queue the outputs expected after it.
    task automatic step(input logic [1:0] st, input int tm, input logic sr,
                        input logic ar, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        e.st = st; e.tm = tm; e.sr = sr; e.ar = ar; e.name = name;
        q.push_back(e);
    endtask

    task automatic idle(input string name);
        step(2'd0, 3, 1'b0, 1'b0, name);
    endtask

    task automatic setst(input string name);
        step(2'd1, 3, 1'b0, 1'b1, name);
    endtask

    // From IDLE with sensor_s low: press, hold two edges, release.
    task automatic arm(input string name);
        btn1 = 1'b0;
        idle({name, "_pulse"});
        setst({name, "_set"});
        btn1 = 1'b1;
    endtask

    // From SET: raise sensor, reach TRIGGER three edges later, drop sensor.
    task automatic trip(input string name);
        sensor = 1'b1;
        setst({name, "_sync1"});
        setst({name, "_sync2"});
        step(2'd2, 3, 1'b0, 1'b1, {name, "_trig"});
        sensor = 1'b0;
    endtask

    initial begin
        rst = 1'b1; btn1 = 1'b1; sensor = 1'b0; passcode_correct = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (system_state !== STATE_IDLE || timer !== 32'sd3 ||
            siren !== 1'b0 || armed !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got state=%0d timer=%0d siren=%0b armed=%0b",
                     system_state, timer, siren, armed);
        end
        idle("reset");
        #1 rst = 1'b0;

        // Sensor activity while idle is ignored.
        sensor = 1'b1;
        for (int i = 0; i < 4; i++) idle("idle_sensor");
        sensor = 1'b0;
        for (int i = 0; i < 3; i++) idle("idle_flush");

        // Arm with a long press; then disarm while the button is still held
        // and check the held button does not re-arm.
        btn1 = 1'b0;
        idle("arm_first_sample");
        setst("arm_set");
        for (int i = 0; i < 3; i++) setst("arm_hold");
        passcode_correct = 1'b1;
        idle("disarm_in_set");
        passcode_correct = 1'b0;
        for (int i = 0; i < 4; i++) idle("oneshot_once");
        btn1 = 1'b1;
        idle("btn_release");

        // Full countdown into ALARM, then auto re-arm.
        arm("arm2");
        trip("trip1");
        for (int i = 1; i <= 12; i++) begin
            if (i < 12) step(2'd2, 3 - i / 4, 1'b0, 1'b1, "countdown");
            else        step(2'd3, 0, 1'b1, 1'b1, "alarm_entry");
        end
        for (int j = 1; j <= 8; j++) begin
            if (j < 8) step(2'd3, 0, 1'b1, 1'b1, "alarm_hold");
            else       setst("auto_rearm");
        end
        setst("rearm_stays_set");

        // Disarm during countdown with timer=2; second high cycle is harmless.
        trip("trip2");
        for (int i = 1; i <= 4; i++) step(2'd2, 3 - i / 4, 1'b0, 1'b1, "countdown2");
        passcode_correct = 1'b1;
        idle("disarm_trigger");
        idle("disarm_hold");
        passcode_correct = 1'b0;
        idle("disarm_after");

        // Passcode coincides with the final tick: disarm wins.
        arm("arm3");
        trip("trip3");
        for (int i = 1; i <= 11; i++) step(2'd2, 3 - i / 4, 1'b0, 1'b1, "countdown3");
        passcode_correct = 1'b1;
        idle("priority_disarm");
        passcode_correct = 1'b0;
        idle("priority_after");

        // Arm pulse and synchronised sensor together in IDLE.
        sensor = 1'b1;
        for (int i = 0; i < 3; i++) idle("presync");
        btn1 = 1'b0;
        idle("simul_pulse");
        setst("simul_set");
        btn1 = 1'b1;
        step(2'd2, 3, 1'b0, 1'b1, "simul_trigger");
        sensor = 1'b0;
        passcode_correct = 1'b1;
        idle("simul_disarm");
        passcode_correct = 1'b0;
        for (int i = 0; i < 2; i++) idle("simul_flush");

        // Reset in the middle of an alarm, then a normal re-arm and countdown.
        arm("arm4");
        trip("trip4");
        for (int i = 1; i <= 12; i++) begin
            if (i < 12) step(2'd2, 3 - i / 4, 1'b0, 1'b1, "countdown4");
            else        step(2'd3, 0, 1'b1, 1'b1, "alarm_entry4");
        end
        step(2'd3, 0, 1'b1, 1'b1, "alarm_mid");
        step(2'd3, 0, 1'b1, 1'b1, "alarm_mid");
        rst = 1'b1;
        idle("reset_mid_alarm");
        rst = 1'b0;
        arm("arm5");
        trip("trip5");
        for (int i = 1; i <= 4; i++) step(2'd2, 3 - i / 4, 1'b0, 1'b1, "countdown5");
        passcode_correct = 1'b1;
        idle("final_disarm");
        passcode_correct = 1'b0;

        @(negedge clk);
        #1;
        r_done = 1'b1;
        if (q.size() != 0 || checks < 12) begin
            errors++;
            $display("FAIL completion: %0d expectations unconsumed, %0d checks run",
                     q.size(), checks);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
